// File: rtl/reset_req_gen.sv
// Reset-request source: turns a watchdog timeout or a key-qualified software
// request into one fixed-width active-low pulse on nRST_out, then a holdoff window.
module reset_req_gen #(
    parameter int unsigned WDT_W     = 16,
    parameter int unsigned PULSE_LEN = 16,
    parameter int unsigned HOLDOFF   = 8,
    parameter int unsigned CW        = 8,
    parameter logic [7:0]  SW_KEY    = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wdt_en,
    input  logic             wdt_kick,
    input  logic [WDT_W-1:0] wdt_load,
    input  logic             sw_rst_req,
    input  logic [7:0]       sw_rst_key,
    output logic             nRST_out,
    output logic             busy,
    output logic [1:0]       cause,
    output logic             key_err,
    output logic [WDT_W-1:0] wdt_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_p_q, cnt_p_d;
    logic              nrst_out_q, nrst_out_d;
    logic              busy_q, busy_d;
    logic [1:0]        cause_q, cause_d;
    logic              key_err_q, key_err_d;
    logic [WDT_W-1:0]  wdt_cnt_q, wdt_cnt_d;

    logic              wdt_trig;
    logic              sw_trig;
    logic              key_bad;

    // Watchdog: kick beats expiry; expiry reloads and fires for one cycle.
    always_comb begin
        wdt_cnt_d = wdt_cnt_q;
        wdt_trig  = 1'b0;
        if (!wdt_en || wdt_kick) begin
            wdt_cnt_d = wdt_load;
        end else if (wdt_cnt_q == '0) begin
            wdt_trig  = 1'b1;
            wdt_cnt_d = wdt_load;
        end else begin
            wdt_cnt_d = wdt_cnt_q - WDT_W'(1);
        end
    end

    assign sw_trig = sw_rst_req && (sw_rst_key == SW_KEY);
    assign key_bad = sw_rst_req && (sw_rst_key != SW_KEY);

    // Pulse sequencer; triggers outside IDLE are dropped.
    always_comb begin
        state_d    = state_q;
        cnt_p_d    = cnt_p_q;
        nrst_out_d = nrst_out_q;
        cause_d    = cause_q;
        key_err_d  = key_err_q | key_bad;

        unique case (state_q)
            IDLE: begin
                if (wdt_trig || sw_trig) begin
                    state_d    = ASSERT;
                    nrst_out_d = 1'b0;
                    cnt_p_d    = CW'(PULSE_LEN - 1);
                    if (cause_q == 2'b00) begin
                        cause_d = {sw_trig, wdt_trig};
                    end
                end
            end
            ASSERT: begin
                nrst_out_d = 1'b0;
                if (cnt_p_q == '0) begin
                    nrst_out_d = 1'b1;
                    if (HOLDOFF == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        cnt_p_d = CW'(HOLDOFF - 1);
                    end
                end else begin
                    cnt_p_d = cnt_p_q - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_p_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_p_d = cnt_p_q - CW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                nrst_out_d = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_p_q    <= '0;
            nrst_out_q <= 1'b1;
            busy_q     <= 1'b0;
            cause_q    <= 2'b00;
            key_err_q  <= 1'b0;
            wdt_cnt_q  <= wdt_load;
        end else begin
            state_q    <= state_d;
            cnt_p_q    <= cnt_p_d;
            nrst_out_q <= nrst_out_d;
            busy_q     <= busy_d;
            cause_q    <= cause_d;
            key_err_q  <= key_err_d;
            wdt_cnt_q  <= wdt_cnt_d;
        end
    end

    assign nRST_out = nrst_out_q;
    assign busy     = busy_q;
    assign cause    = cause_q;
    assign key_err  = key_err_q;
    assign wdt_cnt  = wdt_cnt_q;

endmodule

// File: tb/tb_reset_req_gen.sv
// Directed self-checking bench for reset_req_gen (default parameters).
module tb_reset_req_gen;

    logic        clk;
    logic        rst_n;
    logic        wdt_en;
    logic        wdt_kick;
    logic [15:0] wdt_load;
    logic        sw_rst_req;
    logic [7:0]  sw_rst_key;
    logic        nRST_out;
    logic        busy;
    logic [1:0]  cause;
    logic        key_err;
    logic [15:0] wdt_cnt;

    int checks = 0;
    int errors = 0;

    reset_req_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wdt_en     (wdt_en),
        .wdt_kick   (wdt_kick),
        .wdt_load   (wdt_load),
        .sw_rst_req (sw_rst_req),
        .sw_rst_key (sw_rst_key),
        .nRST_out   (nRST_out),
        .busy       (busy),
        .cause      (cause),
        .key_err    (key_err),
        .wdt_cnt    (wdt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        wdt_en     = 1'b0;
        wdt_kick   = 1'b0;
        sw_rst_req = 1'b0;
        sw_rst_key = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        wdt_load = 16'd3;
        apply_reset();
        checks++; if (nRST_out !== 1'b1) begin errors++; $display("FAIL reset_nrst got %b exp 1", nRST_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (cause !== 2'b00) begin errors++; $display("FAIL reset_cause got %b exp 00", cause); end
        checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL reset_key_err got %b exp 0", key_err); end
        checks++; if (wdt_cnt !== 16'd3) begin errors++; $display("FAIL reset_wdt_cnt got %0d exp 3", wdt_cnt); end
    endtask

    task automatic test_wdt_expiry();
        wdt_load = 16'd3;
        apply_reset();
        wdt_en = 1'b1;
        // edges 0..2: counting down, no pulse
        for (int e = 0; e < 3; e++) begin
            tick();
            checks++; if (nRST_out !== 1'b1) begin errors++; $display("FAIL wdt_pre edge %0d got %b exp 1", e, nRST_out); end
            if (e == 0) begin
                checks++; if (wdt_cnt !== 16'd2) begin errors++; $display("FAIL wdt_cnt_edge0 got %0d exp 2", wdt_cnt); end
            end
        end
        // edges 3..18: pulse low
        for (int e = 3; e < 19; e++) begin
            tick();
            checks++; if (nRST_out !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wdt_pulse edge %0d got nrst=%b busy=%b exp 0/1", e, nRST_out, busy); end
        end
        // edges 19..26: holdoff; expiry at edge 23 must be dropped
        for (int e = 19; e < 27; e++) begin
            tick();
            checks++; if (nRST_out !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL wdt_hold edge %0d got nrst=%b busy=%b exp 1/1", e, nRST_out, busy); end
        end
        // edge 27: back to IDLE, coincident expiry is dropped
        tick();
        wdt_en = 1'b0;
        checks++; if (nRST_out !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wdt_idle got nrst=%b busy=%b exp 1/0", nRST_out, busy); end
        checks++; if (cause !== 2'b01) begin errors++; $display("FAIL wdt_cause got %b exp 01", cause); end
        tick();
        checks++; if (nRST_out !== 1'b1) begin errors++; $display("FAIL wdt_no_repeat got %b exp 1", nRST_out); end
    endtask

    task automatic test_kick_priority();
        wdt_load = 16'd3;
        apply_reset();
        wdt_en = 1'b1;
        for (int e = 0; e < 19; e++) begin
            wdt_kick = (e == 2 || e == 5 || e == 8 || e == 11 || e == 14 || e == 18);
            tick();
            checks++; if (nRST_out !== 1'b1) begin errors++; $display("FAIL kick_nrst edge %0d got %b exp 1", e, nRST_out); end
            if (e == 17) begin
                checks++; if (wdt_cnt !== 16'd0) begin errors++; $display("FAIL kick_cnt_zero got %0d exp 0", wdt_cnt); end
            end
            if (e == 18) begin
                checks++; if (wdt_cnt !== 16'd3) begin errors++; $display("FAIL kick_reload got %0d exp 3", wdt_cnt); end
            end
        end
        wdt_kick = 1'b0;
        wdt_en   = 1'b0;
        checks++; if (busy !== 1'b0 || cause !== 2'b00) begin errors++; $display("FAIL kick_state got busy=%b cause=%b exp 0/00", busy, cause); end
    endtask

    task automatic test_sw_key();
        wdt_load = 16'd3;
        apply_reset();
        sw_rst_req = 1'b1;
        sw_rst_key = 8'h00;
        tick();
        sw_rst_req = 1'b0;
        checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL key_err_set got %b exp 1", key_err); end
        checks++; if (nRST_out !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL key_bad_nrst got nrst=%b busy=%b exp 1/0", nRST_out, busy); end
        tick();
        checks++; if (nRST_out !== 1'b1) begin errors++; $display("FAIL key_bad_after got %b exp 1", nRST_out); end
        sw_rst_req = 1'b1;
        sw_rst_key = 8'hA5;
        tick();
        sw_rst_req = 1'b0;
        checks++; if (nRST_out !== 1'b0) begin errors++; $display("FAIL sw_fall got %b exp 0", nRST_out); end
        checks++; if (cause !== 2'b10) begin errors++; $display("FAIL sw_cause got %b exp 10", cause); end
        for (int i = 1; i < 16; i++) begin
            tick();
            checks++; if (nRST_out !== 1'b0) begin errors++; $display("FAIL sw_low cycle %0d got %b exp 0", i, nRST_out); end
        end
        tick();
        checks++; if (nRST_out !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL sw_rise got nrst=%b busy=%b exp 1/1", nRST_out, busy); end
        repeat (7) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sw_hold_end got %b exp 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sw_idle got %b exp 0", busy); end
        checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL key_err_sticky got %b exp 1", key_err); end
    endtask

    task automatic test_simultaneous();
        wdt_load = 16'd3;
        apply_reset();
        wdt_en = 1'b1;
        repeat (3) tick();
        sw_rst_req = 1'b1;
        sw_rst_key = 8'hA5;
        tick();
        sw_rst_req = 1'b0;
        wdt_en     = 1'b0;
        checks++; if (nRST_out !== 1'b0) begin errors++; $display("FAIL both_fall got %b exp 0", nRST_out); end
        checks++; if (cause !== 2'b11) begin errors++; $display("FAIL both_cause got %b exp 11", cause); end
        for (int i = 1; i < 16; i++) begin
            tick();
            checks++; if (nRST_out !== 1'b0) begin errors++; $display("FAIL both_low cycle %0d got %b exp 0", i, nRST_out); end
        end
        tick();
        checks++; if (nRST_out !== 1'b1) begin errors++; $display("FAIL both_rise got %b exp 1", nRST_out); end
        repeat (8) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL both_idle got %b exp 0", busy); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (nRST_out !== 1'b1) begin errors++; $display("FAIL both_single cycle %0d got %b exp 1", i, nRST_out); end
        end
    endtask

    task automatic test_back_to_back();
        wdt_load = 16'd3;
        apply_reset();
        sw_rst_req = 1'b1;
        sw_rst_key = 8'hA5;
        tick();
        sw_rst_req = 1'b0;
        repeat (15) tick();
        tick();
        checks++; if (nRST_out !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_hold got nrst=%b busy=%b exp 1/1", nRST_out, busy); end
        repeat (4) tick();
        // fifth HOLD edge: request must be ignored
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        checks++; if (nRST_out !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_ignored got nrst=%b busy=%b exp 1/1", nRST_out, busy); end
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", busy); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (nRST_out !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_no_pulse cycle %0d got nrst=%b busy=%b exp 1/0", i, nRST_out, busy); end
        end
        checks++; if (cause !== 2'b10 || key_err !== 1'b0) begin errors++; $display("FAIL b2b_flags got cause=%b key_err=%b exp 10/0", cause, key_err); end
    endtask

    task automatic test_reset_mid_pulse();
        wdt_load = 16'd3;
        apply_reset();
        sw_rst_req = 1'b1;
        sw_rst_key = 8'hA5;
        tick();
        sw_rst_req = 1'b0;
        repeat (5) tick();
        checks++; if (nRST_out !== 1'b0) begin errors++; $display("FAIL mid_low got %b exp 0", nRST_out); end
        rst_n = 1'b0;
        tick();
        checks++; if (nRST_out !== 1'b1) begin errors++; $display("FAIL mid_abort got %b exp 1", nRST_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
        checks++; if (cause !== 2'b00) begin errors++; $display("FAIL mid_cause got %b exp 00", cause); end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (nRST_out !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_stays_idle got nrst=%b busy=%b exp 1/0", nRST_out, busy); end
    endtask

    initial begin
        rst_n      = 1'b0;
        wdt_en     = 1'b0;
        wdt_kick   = 1'b0;
        wdt_load   = 16'd3;
        sw_rst_req = 1'b0;
        sw_rst_key = 8'h00;
        test_reset();
        test_wdt_expiry();
        test_kick_priority();
        test_sw_key();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
